id_stage: RTL
=============

# id_stage

Instruction-decode front end that sits directly downstream of the fetch stage. It holds the IF/ID pipeline register and the 32x32 general-purpose register file with write-back bypass. It also detects read-after-write hazards against the EXE and MEM stages, and flushes on taken branches. It drives PC/instruction, both operand values and a freeze request back to fetch.

## Interface
- No parameters. Widths are fixed: 32-bit data, 32 registers, 5-bit register index.
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-low
- PC_in  in  32  PC+4 from fetch
- Instruction_in  in  32  fetched instruction
- flush  in  1  taken branch from EXE (Br_taken); kill the instruction being captured
- two_src  in  1  decoded current instruction reads src2 (from control unit)
- EXE_WB_EN  in  1  instruction in EXE will write a register
- EXE_Dest  in  5  its destination
- MEM_WB_EN  in  1  instruction in MEM will write a register
- MEM_Dest  in  5  its destination
- WB_WB_EN  in  1  write-back enable
- WB_Dest  in  5  write-back register index
- WB_Value  in  32  write-back data
- PC  out  32  registered PC+4 of instruction in ID
- Instruction  out  32  registered instruction in ID
- Dest  out  5  Instruction[25:21]
- src1  out  5  Instruction[20:16]
- src2  out  5  Instruction[15:11]
- Val_Rn  out  32  register-file read of src1 (bypassed)
- Val_Rm  out  32  register-file read of src2 (bypassed)
- hazard  out  1  RAW hazard; fetch holds its PC and a bubble goes to ID/EX

## Operation
- Instruction format: opcode [31:26], Dest [25:21], src1 [20:16], src2 [15:11], imm [15:0]. 32'b0 is a NOP.
- IF/ID register priority, highest first:
  - reset: PC=0, Instruction=0.
  - flush=1: PC=0, Instruction=0 (bubble).
  - hazard=1: hold both.
  - else: load PC_in and Instruction_in.
- Register file:
  - 32 entries, all cleared to 0 on reset.
  - Write at posedge when WB_WB_EN=1 and WB_Dest!=0.
  - Register 0 always reads 0. Writes to it are ignored.
- Read (combinational), for each src:
  - If src==0, result is 0.
  - Else if WB_WB_EN=1 and WB_Dest==src, result is WB_Value (same-cycle bypass).
  - Else result is the stored value.
- Hazard (combinational) is the OR of:
  - src1!=0 and EXE_WB_EN and src1==EXE_Dest
  - src1!=0 and MEM_WB_EN and src1==MEM_Dest
  - two_src and src2!=0 and EXE_WB_EN and src2==EXE_Dest
  - two_src and src2!=0 and MEM_WB_EN and src2==MEM_Dest
- hazard is forced to 0 while Instruction==0 (NOP/bubble).
- No hazard check against WB; the bypass covers it.

## Timing
- Latency from fetch to ID outputs: 1 cycle.
- Field outputs, Val_Rn, Val_Rm and hazard are combinational from IF/ID contents and inputs, valid in the same cycle.
- While hazard=1, the IF/ID contents repeat every cycle. hazard drops once the producer leaves MEM, typically after 1–2 stall cycles.
- flush together with hazard: flush wins. IF/ID becomes NOP, so hazard is 0 the next cycle.
- Write-back to the register being read in the same cycle returns the new value. The stored copy updates at that edge.
- Asynchronous reset mid-stall or mid-flush:
  - Immediate: PC=0, Instruction=0, hazard=0, registers=0.
  - First capture on the first rising edge after rst deasserts.

## Test plan
- Reset held, then released: PC=0, Instruction=0, Val_Rn=Val_Rm=0, hazard=0. First edge after release loads PC_in=4 and Instruction_in.
- Write R5=0xDEADBEEF via WB. In the same cycle ID reads src1=5 -> Val_Rn=0xDEADBEEF. Next cycle, without WB, it still reads 0xDEADBEEF.
- WB write to R0 with value 0x1234 -> a later read of src1=0 returns 0.
- EXE_Dest=3, EXE_WB_EN=1, ID src2=3 with two_src=1 -> hazard=1 and IF/ID holds. With two_src=0 -> hazard=0.
- Stall then release: producer moves EXE->MEM (hazard stays 1), then leaves MEM -> hazard=0 and IF/ID loads the next instruction.
- flush=1 during hazard=1 -> next edge Instruction=0, PC=0, hazard=0. A NOP with EXE_Dest=0 never raises hazard.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode front end: IF/ID pipeline register, 32x32 register
// file with write-back bypass, and RAW hazard detection against EXE/MEM.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_in,
    input  logic [31:0] Instruction_in,
    input  logic        flush,
    input  logic        two_src,
    input  logic        EXE_WB_EN,
    input  logic [4:0]  EXE_Dest,
    input  logic        MEM_WB_EN,
    input  logic [4:0]  MEM_Dest,
    input  logic        WB_WB_EN,
    input  logic [4:0]  WB_Dest,
    input  logic [31:0] WB_Value,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic [4:0]  Dest,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic [31:0] Val_Rn,
    output logic [31:0] Val_Rm,
    output logic        hazard
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IDX_W = 5;

    logic [DATA_W-1:0] rf [NUM_REGS];

    // Instruction field extraction
    assign Dest = Instruction[25:21];
    assign src1 = Instruction[20:16];
    assign src2 = Instruction[15:11];

    // IF/ID register: flush inserts a bubble, hazard holds, otherwise capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC          <= '0;
            Instruction <= '0;
        end else if (flush) begin
            PC          <= '0;
            Instruction <= '0;
        end else if (!hazard) begin
            PC          <= PC_in;
            Instruction <= Instruction_in;
        end
    end

    // Register file write port; register 0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf[i] <= '0;
            end
        end else if (WB_WB_EN && (WB_Dest != IDX_W'(0))) begin
            rf[WB_Dest] <= WB_Value;
        end
    end

    // Operand reads with same-cycle write-back bypass; register 0 reads zero
    always_comb begin
        Val_Rn = '0;
        Val_Rm = '0;
        if (src1 != IDX_W'(0)) begin
            if (WB_WB_EN && (WB_Dest == src1)) Val_Rn = WB_Value;
            else                                Val_Rn = rf[src1];
        end
        if (src2 != IDX_W'(0)) begin
            if (WB_WB_EN && (WB_Dest == src2)) Val_Rm = WB_Value;
            else                                Val_Rm = rf[src2];
        end
    end

    // RAW hazard against EXE and MEM producers; a NOP/bubble never stalls
    always_comb begin
        hazard = 1'b0;
        if (Instruction != DATA_W'(0)) begin
            if (src1 != IDX_W'(0)) begin
                if (EXE_WB_EN && (src1 == EXE_Dest)) hazard = 1'b1;
                if (MEM_WB_EN && (src1 == MEM_Dest)) hazard = 1'b1;
            end
            if (two_src && (src2 != IDX_W'(0))) begin
                if (EXE_WB_EN && (src2 == EXE_Dest)) hazard = 1'b1;
                if (MEM_WB_EN && (src2 == MEM_Dest)) hazard = 1'b1;
            end
        end
    end

endmodule
